aes_sub_bytes: RTL and testbench



---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_sbox.sv | 19 +
 rtl/aes_sub_bytes.sv | 48 ++++
 tb/tb_aes_sub_bytes.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES state/byte types and S-box tables.
// INV_SBOX is only present when AES_SUB_BYTES_INV_EN is defined.
package aes_pkg;

  typedef logic [0:127] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int NUM_BYTES = 16;

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_SUB_BYTES_INV_EN
  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  function automatic aes_byte_t sbox(input aes_byte_t b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational 8-bit S-box lookup.
// With AES_SUB_BYTES_INV_EN defined, i_inv selects the inverse table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
`ifdef AES_SUB_BYTES_INV_EN
  input  logic       i_inv,
`endif
  output logic [7:0] o_byte
);

`ifdef AES_SUB_BYTES_INV_EN
  assign o_byte = i_inv ? INV_SBOX[i_byte] : sbox(i_byte);
`else
  assign o_byte = sbox(i_byte);
`endif

endmodule

// File: rtl/aes_sub_bytes.sv
// rtl/aes_sub_bytes.sv - registered SubBytes stage over a 128-bit AES state.
// AES_SUB_BYTES_INV_EN adds the inv port selecting InvSubBytes.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
`ifdef AES_SUB_BYTES_INV_EN
  input  logic         inv,
`endif
  input  logic [0:127] in_data,
  output logic         out_valid,
  output logic [0:127] out_data
);

  aes_state_t w_sub;
  aes_state_t r_data;
  logic       r_valid;

  // byte k occupies in_data[8k:8k+7], byte 0 is the leftmost byte
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    aes_sbox u_sbox (
      .i_byte (in_data[8*k +: 8]),
`ifdef AES_SUB_BYTES_INV_EN
      .i_inv  (inv),
`endif
      .o_byte (w_sub[8*k +: 8])
    );
  end

  // data only loads on valid so X on an idle bus never reaches the output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_sub;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// tb/tb_aes_sub_bytes.sv - scoreboard bench for aes_sub_bytes against a GF(2^8) S-box model.
// Define AES_SUB_BYTES_INV_EN to also exercise the inverse path.
module tb_aes_sub_bytes;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [0:127] in_data;
  logic         out_valid;
  logic [0:127] out_data;
`ifdef AES_SUB_BYTES_INV_EN
  logic         inv;
`endif

  aes_sub_bytes dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
`ifdef AES_SUB_BYTES_INV_EN
    .inv       (inv),
`endif
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   ref_sbox [256];
  logic [7:0]   ref_inv  [256];
  logic [0:127] exp_q [$];
  logic [0:127] last_data;

  localparam logic [0:127] V_PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] V_CT  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] V_ORD = 128'h000153ff000153ff000153ff000153ff;
  localparam logic [0:127] E_ORD = 128'h637ced16637ced16637ced16637ced16;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [0:127] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [0:127] model_fwd(input logic [0:127] d);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox[d[8*k +: 8]];
    return r;
  endfunction

  // one clock: drive, clock, then compare what the DUT shows one edge later
  task automatic step(input logic r, input logic v, input logic [0:127] d, input logic [0:127] e);
    logic [0:127] e_pop;
    rst      = r;
    in_valid = v;
    in_data  = d;
    if (v && !r) exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq("out_valid", 128'(out_valid), 128'(v && !r));
    if (r) begin
      check_eq("rst_data", out_data, '0);
      last_data = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 128'(exp_q.size()), 128'd1);
      end else begin
        e_pop = exp_q.pop_front();
        check_eq("out_data", out_data, e_pop);
        last_data = e_pop;
      end
    end else begin
      check_eq("hold_data", out_data, last_data);
    end
  endtask

  initial begin
    logic [0:127] d;
    logic [7:0]   inv_b;

    for (int a = 0; a < 256; a++) begin
      inv_b = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv_b = 8'(b);
      ref_sbox[a] = inv_b ^ rotl8(inv_b, 1) ^ rotl8(inv_b, 2) ^ rotl8(inv_b, 3) ^ rotl8(inv_b, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) ref_inv[ref_sbox[a]] = 8'(a);
    last_data = '0;
`ifdef AES_SUB_BYTES_INV_EN
    inv = 1'b0;
`endif

    step(1'b1, 1'b1, V_PT, '0);
    step(1'b1, 1'b1, V_PT, '0);
    step(1'b0, 1'b1, V_PT, V_CT);
    step(1'b0, 1'b1, '0, rep(8'h63));
    step(1'b0, 1'b1, '1, rep(8'h16));
    step(1'b0, 1'b1, V_ORD, E_ORD);
    step(1'b0, 1'b0, 'x, '0);

    step(1'b0, 1'b1, V_PT, V_CT);
    step(1'b1, 1'b1, '1, '0);
    step(1'b0, 1'b0, 'x, '0);

    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(1'b0, 1'b1, d, model_fwd(d));
      step(1'b0, 1'b0, 'x, '0);
    end

    for (int b = 0; b < 256; b++) begin
      step(1'b0, 1'b1, rep(8'(b)), rep(ref_sbox[b]));
    end
    step(1'b0, 1'b0, 'x, '0);

`ifdef AES_SUB_BYTES_INV_EN
    inv = 1'b1;
    step(1'b0, 1'b1, V_CT, V_PT);
    step(1'b0, 1'b1, rep(8'h63), '0);
    for (int b = 0; b < 256; b += 37) begin
      step(1'b0, 1'b1, rep(8'(b)), rep(ref_inv[b]));
    end
    inv = 1'b0;
    step(1'b0, 1'b1, V_PT, V_CT);
    step(1'b0, 1'b0, 'x, '0);
`endif

    check_eq("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
